// File: rtl/dmux_router.sv
// rtl/dmux_router.sv - one-word demultiplexing router with per-channel pending mask
//
// Purpose:
//   Holds a single payload word and a CHANNELS-bit pending mask. An accepted
//   word is steered to the channel named by in_sel (one-hot pending bit) and
//   stays visible until every pending channel has consumed it. Words whose
//   in_sel is out of range are dropped and flagged with a one-cycle sel_err.
//   Optional broadcast (macro DMUX_ROUTER_BCAST_EN) adds in_bcast, which marks
//   every channel pending for the accepted word.
//
// Ports:
//   clk        in   1         clock, all state on rising edge
//   reset      in   1         synchronous active-high reset
//   in_valid   in   1         upstream offers a word
//   in_ready   out  1         word accepted this cycle when in_valid is high
//   in_data    in   WIDTH     payload
//   in_sel     in   SEL_W     destination channel index
//   in_bcast   in   1         broadcast request (only with DMUX_ROUTER_BCAST_EN)
//   out_valid  out  CHANNELS  bit k: channel k holds a word
//   out_ready  in   CHANNELS  bit k: channel k consumes this cycle
//   out_data   out  WIDTH     registered payload shared by all channels
//   sel_err    out  1         one-cycle pulse for a dropped out-of-range word

module dmux_router #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_data,
   input  logic [SEL_W-1:0]    in_sel,
`ifdef DMUX_ROUTER_BCAST_EN
   input  logic                in_bcast,
`endif
   output logic [CHANNELS-1:0] out_valid,
   input  logic [CHANNELS-1:0] out_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic                sel_err
);

   // One extra bit so the range check also works when CHANNELS == 2**SEL_W.
   localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

   logic [CHANNELS-1:0] pending_q, pending_d;
   logic [WIDTH-1:0]    data_q, data_d;
   logic                sel_err_q, sel_err_d;

   logic [CHANNELS-1:0] drained;
   logic [CHANNELS-1:0] sel_onehot;
   logic                sel_ok;
   logic                bcast;
   logic                accept;

`ifdef DMUX_ROUTER_BCAST_EN
   assign bcast = in_bcast;
`else
   assign bcast = 1'b0;
`endif

   assign sel_ok = ({1'b0, in_sel} < CH_LIMIT);

   always_comb begin
      sel_onehot = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         sel_onehot[k] = (in_sel == SEL_W'(k));
      end
   end

   // Pending bits that survive this cycle; ready bits of idle channels drop out.
   assign drained = pending_q & ~out_ready;

   // Ready as soon as nothing would still be pending after this edge, which
   // lets a new word land in the same cycle the last channel drains.
   assign in_ready = ~reset & (drained == '0);
   assign accept   = in_valid & in_ready;

   always_comb begin
      pending_d = drained;
      data_d    = data_q;
      sel_err_d = 1'b0;
      if (accept) begin
         if (bcast) begin
            pending_d = '1;
            data_d    = in_data;
         end else if (sel_ok) begin
            pending_d = sel_onehot;
            data_d    = in_data;
         end else begin
            // Out-of-range word is consumed and dropped; the register keeps
            // its previous payload and only the drain update applies.
            sel_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         data_q    <= '0;
         sel_err_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         data_q    <= data_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign out_valid = pending_q;
   assign out_data  = data_q;
   assign sel_err   = sel_err_q;

endmodule
